// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight register writes, stalls
// decode on pending sources, squashes the fetch slot on taken branches and
// keeps saturating stall/flush counters.
module hazard_scoreboard #(
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_dec_valid,
  input  logic [4:0]       i_rs1_num,
  input  logic [4:0]       i_rs2_num,
  input  logic             i_rs1_used,
  input  logic             i_rs2_used,
  input  logic [4:0]       i_rd_num,
  input  logic             i_rd_wr,
  input  logic             i_b_taken,
  input  logic             i_wb_valid,
  input  logic [4:0]       i_wb_rd_num,
  input  logic             i_cnt_clr,
  output logic             o_stall,
  output logic             o_bubble,
  output logic             o_issue,
  output logic             o_flush_if,
  output logic [31:0]      o_pending,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  logic [31:0] pend_q, pend_d;
  logic [31:0] rdy;
  logic        haz;

  // Per-register ready: x0 always ready, otherwise not pending or (optionally)
  // being written back this very cycle.
  for (genvar n = 0; n < 32; n++) begin : g_rdy
    if (n == 0) begin : g_x0
      assign rdy[n] = 1'b1;
    end else begin : g_xn
      assign rdy[n] = ~pend_q[n] |
                      (WB_BYPASS & i_wb_valid & (i_wb_rd_num == 5'(n)));
    end
  end

  // Hazard detection and the zero-latency pipeline control outputs.
  always_comb begin
    haz        = i_dec_valid & ((i_rs1_used & ~rdy[i_rs1_num]) |
                                (i_rs2_used & ~rdy[i_rs2_num]));
    o_stall    = haz;
    o_bubble   = haz;
    o_issue    = i_dec_valid & ~haz;
    // Branch result from a stalled instruction used stale operands; ignore it.
    o_flush_if = o_issue & i_b_taken;
  end

  // Scoreboard next state: clear on writeback, then set on issue so a newer
  // writer to the same register stays pending.
  always_comb begin
    pend_d = pend_q;
    if (i_wb_valid)
      pend_d[i_wb_rd_num] = 1'b0;
    if (o_issue && i_rd_wr && (i_rd_num != 5'd0))
      pend_d[i_rd_num] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Scoreboard register; reset drops every in-flight write.
  always_ff @(posedge i_clk) begin
    if (i_rst) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  assign o_pending = pend_q;

  hs_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_cnt_clr),
    .i_inc (o_stall),
    .o_cnt (o_stall_cnt)
  );

  hs_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_cnt_clr),
    .i_inc (o_flush_if),
    .o_cnt (o_flush_cnt)
  );

endmodule

// Saturating event counter with clear-over-increment priority.
module hs_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment until all-ones and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr)
      cnt_d = '0;
    else if (i_inc && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a vector table on a bypassing
// instance plus hand sequences for saturation and the non-bypass timing.
module tb_hazard_scoreboard;

  localparam int CW = 4;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic       i_rst, i_dec_valid, i_rs1_used, i_rs2_used, i_rd_wr;
  logic       i_b_taken, i_wb_valid, i_cnt_clr;
  logic [4:0] i_rs1_num, i_rs2_num, i_rd_num, i_wb_rd_num;

  logic          a_stall, a_bubble, a_issue, a_flush;
  logic [31:0]   a_pend;
  logic [CW-1:0] a_sc, a_fc;
  logic          b_stall, b_bubble, b_issue, b_flush;
  logic [31:0]   b_pend;
  logic [CW-1:0] b_sc, b_fc;

  hazard_scoreboard #(.WB_BYPASS(1'b1), .CNT_W(CW)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_dec_valid(i_dec_valid),
    .i_rs1_num(i_rs1_num), .i_rs2_num(i_rs2_num),
    .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
    .i_rd_num(i_rd_num), .i_rd_wr(i_rd_wr), .i_b_taken(i_b_taken),
    .i_wb_valid(i_wb_valid), .i_wb_rd_num(i_wb_rd_num), .i_cnt_clr(i_cnt_clr),
    .o_stall(a_stall), .o_bubble(a_bubble), .o_issue(a_issue),
    .o_flush_if(a_flush), .o_pending(a_pend),
    .o_stall_cnt(a_sc), .o_flush_cnt(a_fc)
  );

  hazard_scoreboard #(.WB_BYPASS(1'b0), .CNT_W(CW)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_dec_valid(i_dec_valid),
    .i_rs1_num(i_rs1_num), .i_rs2_num(i_rs2_num),
    .i_rs1_used(i_rs1_used), .i_rs2_used(i_rs2_used),
    .i_rd_num(i_rd_num), .i_rd_wr(i_rd_wr), .i_b_taken(i_b_taken),
    .i_wb_valid(i_wb_valid), .i_wb_rd_num(i_wb_rd_num), .i_cnt_clr(i_cnt_clr),
    .o_stall(b_stall), .o_bubble(b_bubble), .o_issue(b_issue),
    .o_flush_if(b_flush), .o_pending(b_pend),
    .o_stall_cnt(b_sc), .o_flush_cnt(b_fc)
  );

  typedef struct {
    logic       rst, dv, u1, u2, wr, bt, wbv, clr;
    logic [4:0] rs1, rs2, rd, wbrd;
    logic       st, is, fl;       // combinational, checked before the edge
    logic [31:0] pend;            // registered, checked after the edge
    logic [3:0]  sc, fc;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic rst, logic dv, logic [4:0] rs1, logic u1,
                              logic [4:0] rs2, logic u2, logic [4:0] rd,
                              logic wr, logic bt, logic wbv, logic [4:0] wbrd,
                              logic clr, logic st, logic is, logic fl,
                              logic [31:0] pend, logic [3:0] sc, logic [3:0] fc);
    vec_t v;
    v.rst = rst; v.dv = dv; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.rd = rd; v.wr = wr; v.bt = bt; v.wbv = wbv; v.wbrd = wbrd; v.clr = clr;
    v.st = st; v.is = is; v.fl = fl; v.pend = pend; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_rst = v.rst; i_dec_valid = v.dv; i_rs1_num = v.rs1; i_rs1_used = v.u1;
    i_rs2_num = v.rs2; i_rs2_used = v.u2; i_rd_num = v.rd; i_rd_wr = v.wr;
    i_b_taken = v.bt; i_wb_valid = v.wbv; i_wb_rd_num = v.wbrd; i_cnt_clr = v.clr;
  endtask

  // Quick helpers for hand sequences: idle cycle, and a plain decode.
  task automatic idle_in();
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
  endtask

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  initial begin
    vec_t v;
    idle_in();
    //        rst dv rs1 u1 rs2 u2 rd wr bt wbv wbrd clr  st is fl pend        sc fc
    tbl.push_back(mk(1,0, 0,0, 0,0, 0,0,0,0, 0,0,  0,0,0,32'h000,  0,0)); // reset
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0,0, 0,0,  0,0,0,32'h000,  0,0)); // idle
    tbl.push_back(mk(0,1, 0,1, 0,0, 5,1,0,0, 0,0,  0,1,0,32'h020,  0,0)); // addi x5
    tbl.push_back(mk(0,1, 5,1, 0,0, 0,0,0,0, 0,0,  1,0,0,32'h020,  1,0)); // RAW stall
    tbl.push_back(mk(0,1, 5,1, 0,0, 0,0,0,1, 5,0,  0,1,0,32'h000,  1,0)); // wb bypass
    tbl.push_back(mk(0,1, 0,1, 0,0, 0,1,0,0, 0,0,  0,1,0,32'h000,  1,0)); // rd=x0
    tbl.push_back(mk(0,1, 0,1, 0,0, 7,1,0,0, 0,0,  0,1,0,32'h080,  1,0)); // set x7
    tbl.push_back(mk(0,1, 0,1, 7,0, 0,0,0,0, 0,0,  0,1,0,32'h080,  1,0)); // rs2 unused
    tbl.push_back(mk(0,0, 7,1, 0,0, 0,0,0,0, 0,0,  0,0,0,32'h080,  1,0)); // dv=0
    tbl.push_back(mk(0,1, 0,0, 0,0, 3,1,0,0, 0,0,  0,1,0,32'h088,  1,0)); // set x3
    tbl.push_back(mk(0,1, 0,0, 0,0, 3,1,0,1, 3,0,  0,1,0,32'h088,  1,0)); // set wins
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0,1, 9,0,  0,0,0,32'h088,  1,0)); // wb x9 noop
    tbl.push_back(mk(0,1, 0,0, 0,0, 4,1,0,0, 0,0,  0,1,0,32'h098,  1,0)); // set x4
    tbl.push_back(mk(0,1, 4,1, 0,0, 0,0,1,0, 0,0,  1,0,0,32'h098,  2,0)); // beq stalled
    tbl.push_back(mk(0,1, 4,1, 0,0, 0,0,1,1, 4,0,  0,1,1,32'h088,  2,1)); // beq issues
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,1,1, 3,0,  0,0,0,32'h080,  2,1)); // taken, dv=0
    tbl.push_back(mk(0,1, 0,0, 0,0, 8,1,0,1, 7,0,  0,1,0,32'h100,  2,1)); // set x8
    tbl.push_back(mk(0,1, 0,0, 0,0, 5,1,0,0, 0,0,  0,1,0,32'h120,  2,1)); // set x5
    tbl.push_back(mk(0,1, 8,1, 0,0, 0,0,0,0, 0,0,  1,0,0,32'h120,  3,1)); // stall x8
    tbl.push_back(mk(1,1, 8,1, 0,0, 0,0,0,0, 0,0,  1,0,0,32'h000,  0,0)); // reset
    tbl.push_back(mk(0,1, 8,1, 0,0, 0,0,0,0, 0,0,  0,1,0,32'h000,  0,0)); // unblocked
    tbl.push_back(mk(0,1, 0,0, 0,0, 2,1,0,0, 0,0,  0,1,0,32'h004,  0,0)); // set x2
    tbl.push_back(mk(0,1, 0,1, 2,1, 0,0,0,0, 0,0,  1,0,0,32'h004,  1,0)); // rs2 stall
    tbl.push_back(mk(0,1, 0,1, 2,1, 0,0,0,0, 0,1,  1,0,0,32'h004,  0,0)); // clr wins
    tbl.push_back(mk(0,0, 0,0, 0,0, 0,0,0,1, 2,0,  0,0,0,32'h000,  0,0)); // drain

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v);
      @(negedge i_clk);
      chk($sformatf("r%0d stall", i),  {31'd0, a_stall},  {31'd0, v.st});
      chk($sformatf("r%0d bubble", i), {31'd0, a_bubble}, {31'd0, v.st});
      chk($sformatf("r%0d issue", i),  {31'd0, a_issue},  {31'd0, v.is});
      chk($sformatf("r%0d flush", i),  {31'd0, a_flush},  {31'd0, v.fl});
      tick();
      chk($sformatf("r%0d pending", i), a_pend, v.pend);
      chk($sformatf("r%0d stall_cnt", i), {28'd0, a_sc}, {28'd0, v.sc});
      chk($sformatf("r%0d flush_cnt", i), {28'd0, a_fc}, {28'd0, v.fc});
    end

    // Stall counter saturates at all-ones.
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0)); tick();
    drive(mk(0,1,0,0,0,0,1,1,0,0,0,0, 0,0,0,0,0,0)); tick();
    drive(mk(0,1,1,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
    for (int c = 0; c < 18; c++) tick();
    chk("sat stall_cnt", {28'd0, a_sc}, 32'hF);
    @(negedge i_clk);
    chk("sat still stalling", {31'd0, a_stall}, 32'd1);
    tick();
    chk("sat hold", {28'd0, a_sc}, 32'hF);

    // Bypass vs non-bypass on the same back-to-back RAW sequence.
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0)); tick();
    drive(mk(0,1,0,1,0,0,5,1,0,0,0,0, 0,0,0,0,0,0)); tick();   // addi x5
    chk("b pend x5", b_pend, 32'h20);
    drive(mk(0,1,5,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));           // RAW read
    @(negedge i_clk);
    chk("b raw stall", {31'd0, b_stall}, 32'd1);
    tick();
    drive(mk(0,1,5,1,0,0,0,0,0,1,5,0, 0,0,0,0,0,0));           // wb x5
    @(negedge i_clk);
    chk("a wb issue", {31'd0, a_issue}, 32'd1);
    chk("b wb stall", {31'd0, b_stall}, 32'd1);
    chk("b wb issue", {31'd0, b_issue}, 32'd0);
    tick();
    chk("b pend cleared", b_pend, 32'h0);
    drive(mk(0,1,5,1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));           // retry
    @(negedge i_clk);
    chk("b late issue", {31'd0, b_issue}, 32'd1);
    chk("b late stall", {31'd0, b_stall}, 32'd0);
    tick();
    chk("a stall_cnt", {28'd0, a_sc}, 32'd1);
    chk("b stall_cnt", {28'd0, b_sc}, 32'd2);
    idle_in(); tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
